// File: rtl/sp_usb_dev_if.sv
// Host-side byte FIFO port bundle for sp_usb_dev.
// master = host logic (pushes TX, pops RX), slave = the device.
interface sp_usb_dev_if;
    logic [7:0] tx_din;
    logic       tx_write;
    logic       tx_full;
    logic [7:0] rx_dout;
    logic       rx_read;
    logic       rx_avail;

    modport master (output tx_din, tx_write, rx_read,
                    input  tx_full, rx_dout, rx_avail);
    modport slave  (input  tx_din, tx_write, rx_read,
                    output tx_full, rx_dout, rx_avail);
endinterface

// File: rtl/sp_usb_dev.sv
// FT245-style USB FIFO device: TX/RX byte FIFOs bridged to an async rd_n/wr_n bus.
// Define SP_USB_DEV_LOOPBACK_EN to route bus-written bytes back into the TX FIFO.
//
// state     | meaning
// R_IDLE    | waiting for a controller read strobe
// R_ACTIVE  | rd_n low, head byte on the bus
// R_RECOVER | holding rxf_n high for RECOVER cycles after rd_n rose
// W_IDLE    | waiting for a controller write strobe
// W_ACTIVE  | wr_n low, byte captured
// W_RECOVER | holding txe_n high for RECOVER cycles after wr_n rose
module sp_usb_dev #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RECOVER    = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [7:0]  usb_data,
    output logic        rxf_n,
    output logic        txe_n,
    input  logic        rd_n,
    input  logic        wr_n,
    sp_usb_dev_if.slave host
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int CW     = (RECOVER > 2) ? $clog2(RECOVER) : 1;
    localparam int REC_LD = (RECOVER > 0) ? RECOVER - 1 : 0;

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_RECOVER} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RECOVER} w_state_t;

    // Strobe synchronizers and aligned bus sample
    logic [2:0] rd_sync, wr_sync;
    logic [7:0] data_s1, data_s2;
    logic       rd_armed, wr_armed;
    logic       rd_rise, rd_fall, wr_fall, wr_rise;

    // Sync flops reset low and edges stay blocked until the strobe is seen
    // high, so a strobe held low across reset is never mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync  <= '0;
            wr_sync  <= '0;
            rd_armed <= 1'b0;
            wr_armed <= 1'b0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            rd_sync <= {rd_sync[1:0], rd_n};
            wr_sync <= {wr_sync[1:0], wr_n};
            data_s1 <= usb_data;
            data_s2 <= data_s1;
            if (rd_sync[1]) rd_armed <= 1'b1;
            if (wr_sync[1]) wr_armed <= 1'b1;
        end
    end

    assign rd_rise = rd_armed &  rd_sync[1] & ~rd_sync[2];
    assign rd_fall = rd_armed & ~rd_sync[1] &  rd_sync[2];
    assign wr_rise = wr_armed &  wr_sync[1] & ~wr_sync[2];
    assign wr_fall = wr_armed & ~wr_sync[1] &  wr_sync[2];

    // FIFOs
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic          tx_empty, tx_full_i, rx_empty, rx_full_i;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]    tx_push_data, tx_head;

    assign tx_empty  = (tx_wp == tx_rp);
    assign rx_empty  = (rx_wp == rx_rp);
    assign tx_full_i = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[PW-2:0] == tx_rp[PW-2:0]);
    assign rx_full_i = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[PW-2:0] == rx_rp[PW-2:0]);

    assign tx_pop = rd_rise & ~tx_empty;
`ifdef SP_USB_DEV_LOOPBACK_EN
    assign tx_push      = wr_fall & (~tx_full_i | tx_pop);
    assign tx_push_data = data_s2;
    assign rx_pop       = 1'b0;
    assign rx_push      = 1'b0;
`else
    assign tx_push      = host.tx_write & (~tx_full_i | tx_pop);
    assign tx_push_data = host.tx_din;
    assign rx_pop       = host.rx_read & ~rx_empty;
    assign rx_push      = wr_fall & (~rx_full_i | rx_pop);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[PW-2:0]] <= tx_push_data;
        if (rx_push) rx_mem[rx_wp[PW-2:0]] <= data_s2;
    end

    assign tx_head       = tx_empty ? 8'h00 : tx_mem[tx_rp[PW-2:0]];
    assign usb_data      = (!rd_n && !rst) ? tx_head : 8'hzz;
    assign host.tx_full  = tx_full_i & ~rst;
    assign host.rx_avail = ~rx_empty & ~rst;
    assign host.rx_dout  = (rx_empty || rst) ? 8'h00 : rx_mem[rx_rp[PW-2:0]];

    // Read-side FSM
    r_state_t      r_state, r_state_nx;
    logic [CW-1:0] r_cnt, r_cnt_nx;
    logic          rxf_n_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            rxf_n   <= 1'b1;
        end else begin
            r_state <= r_state_nx;
            r_cnt   <= r_cnt_nx;
            rxf_n   <= rxf_n_nx;
        end
    end

    always_comb begin
        r_state_nx = r_state;
        r_cnt_nx   = r_cnt;
        case (r_state)
            R_IDLE:    if (rd_fall) r_state_nx = R_ACTIVE;
            R_ACTIVE:  if (rd_rise) begin
                           r_state_nx = R_RECOVER;
                           r_cnt_nx   = CW'(REC_LD);
                       end
            R_RECOVER: if (r_cnt == '0) r_state_nx = R_IDLE;
                       else             r_cnt_nx   = r_cnt - 1'b1;
            default:   r_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        rxf_n_nx = !((r_state == R_IDLE) && !tx_empty);
    end

    // Write-side FSM
    w_state_t      w_state, w_state_nx;
    logic [CW-1:0] w_cnt, w_cnt_nx;
    logic          txe_n_nx;
    logic          accept_ok;

`ifdef SP_USB_DEV_LOOPBACK_EN
    assign accept_ok = ~tx_full_i;
`else
    assign accept_ok = ~rx_full_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            txe_n   <= 1'b1;
        end else begin
            w_state <= w_state_nx;
            w_cnt   <= w_cnt_nx;
            txe_n   <= txe_n_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        w_cnt_nx   = w_cnt;
        case (w_state)
            W_IDLE:    if (wr_fall) w_state_nx = W_ACTIVE;
            W_ACTIVE:  if (wr_rise) begin
                           w_state_nx = W_RECOVER;
                           w_cnt_nx   = CW'(REC_LD);
                       end
            W_RECOVER: if (w_cnt == '0) w_state_nx = W_IDLE;
                       else             w_cnt_nx   = w_cnt - 1'b1;
            default:   w_state_nx = W_IDLE;
        endcase
    end

    always_comb begin
        txe_n_nx = !((w_state == W_IDLE) && accept_ok);
    end
endmodule

// File: tb/tb_sp_usb_dev.sv
// Randomized and directed bench for sp_usb_dev against a queue-based model.
// Build with SP_USB_DEV_LOOPBACK_EN defined to exercise the loopback variant.
module tb_sp_usb_dev;
    localparam int DEPTH   = 16;
    localparam int RECOVER = 2;
`ifdef SP_USB_DEV_LOOPBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    logic       rxf_n, txe_n;
    wire  [7:0] usb_data;

    assign usb_data = drv_en ? drv_val : 8'hzz;

    sp_usb_dev_if hif ();

    sp_usb_dev #(.DEPTH_LOG2(4), .RECOVER(RECOVER)) dut (
        .clk      (clk),
        .rst      (rst),
        .usb_data (usb_data),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .host     (hif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_rxf_n", rxf_n, 1);
        check_val("rst_txe_n", txe_n, 1);
        check_val("rst_tx_full", hif.tx_full, 0);
        check_val("rst_rx_avail", hif.rx_avail, 0);
        check_val("rst_rx_dout", hif.rx_dout, 8'h00);
        rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check_val({tag, ":tx_full"}, hif.tx_full, tx_q.size() == DEPTH);
        check_val({tag, ":rx_avail"}, hif.rx_avail, rx_q.size() > 0);
        check_val({tag, ":rx_dout"}, hif.rx_dout, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        check_val({tag, ":rxf_n"}, rxf_n, tx_q.size() == 0);
        check_val({tag, ":txe_n"}, txe_n, LOOP ? (tx_q.size() == DEPTH) : (rx_q.size() == DEPTH));
    endtask

    task automatic host_write(input logic [7:0] b);
        hif.tx_din   = b;
        hif.tx_write = 1'b1;
        @(negedge clk);
        hif.tx_write = 1'b0;
        if (!LOOP && tx_q.size() < DEPTH) tx_q.push_back(b);
    endtask

    task automatic host_read();
        check_val("hrd_avail", hif.rx_avail, rx_q.size() > 0);
        check_val("hrd_dout", hif.rx_dout, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        hif.rx_read = 1'b1;
        @(negedge clk);
        hif.rx_read = 1'b0;
        if (!LOOP && rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic bus_read(input bit chk_rec);
        logic [7:0] exp;
        exp = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        rd_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("bus_rd_data", usb_data, exp);
        end
        @(negedge clk);
        rd_n = 1'b1;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        if (chk_rec) begin
            repeat (RECOVER) @(negedge clk);
            check_val("rxf_n_recover", rxf_n, 1);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] b, input bit with_read);
        bit popped;
        drv_val = b;
        drv_en  = 1'b1;
        @(negedge clk);
        wr_n = 1'b0;
        repeat (2) @(negedge clk);
        drv_en = 1'b0;
        if (with_read) hif.rx_read = 1'b1;
        @(negedge clk);
        hif.rx_read = 1'b0;
        wr_n = 1'b1;
        if (LOOP) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(b);
        end else begin
            popped = with_read && (rx_q.size() > 0);
            if (rx_q.size() < DEPTH || popped) rx_q.push_back(b);
            if (popped) void'(rx_q.pop_front());
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_rxf_low(input int max_cyc);
        int n = 0;
        while (rxf_n !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val("rxf_n_ready", rxf_n, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        hif.tx_din   = 8'h00;
        hif.tx_write = 1'b0;
        hif.rx_read  = 1'b0;
        apply_reset();
        check_state("post_reset");

`ifndef SP_USB_DEV_LOOPBACK_EN
        // Bus read of a host-written byte, with recovery hold on rxf_n
        host_write(8'hA5);
        @(negedge clk);
        check_val("rxf_n_after_write", rxf_n, 0);
        host_write(8'h11);
        bus_read(1'b1);
        wait_rxf_low(10);
        bus_read(1'b0);
        check_state("read_done");

        // Bus write into RX and host pop
        bus_write(8'h3C, 1'b0);
        check_val("wr_rx_avail", hif.rx_avail, 1);
        check_val("wr_rx_dout", hif.rx_dout, 8'h3C);
        host_read();
        check_state("rx_drained");

        // TX full, overflow ignored, ordered drain, then empty reads 00
        for (int i = 0; i < DEPTH; i++) host_write(8'h40 + 8'(i));
        check_state("tx_full");
        host_write(8'hFF);
        check_state("tx_overflow");
        for (int i = 0; i <= DEPTH; i++) bus_read(1'b0);
        check_state("tx_empty");

        // RX full with simultaneous pop and push
        for (int i = 0; i < DEPTH; i++) bus_write(8'h80 + 8'(i), 1'b0);
        check_state("rx_full");
        bus_write(8'hEE, 1'b0);
        check_state("rx_drop");
        bus_write(8'hD7, 1'b1);
        check_state("rx_simul");
        for (int i = 0; i < DEPTH; i++) host_read();
        check_state("rx_drained2");

        // Reset mid read strobe; strobe held across reset must not pop
        host_write(8'h21);
        bus_write(8'h22, 1'b0);
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        apply_reset();
        check_state("mid_rd_reset");
        host_write(8'h42);
        rd_n = 1'b1;
        repeat (8) @(negedge clk);
        check_state("no_stale_rise");
        bus_read(1'b0);
        check_state("after_stale");

        // Write strobe held across reset must not push
        wr_n = 1'b0;
        apply_reset();
        drv_val = 8'h99;
        drv_en  = 1'b1;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        repeat (2) @(negedge clk);
        drv_en = 1'b0;
        repeat (6) @(negedge clk);
        check_state("no_stale_fall");
`else
        bus_write(8'h5A, 1'b0);
        check_state("loop_push");
        bus_read(1'b0);
        check_state("loop_read");
        host_write(8'h77);
        host_read();
        check_state("loop_host_ignored");
`endif

        // Randomized mix against the queue model
        for (int it = 0; it < 120; it++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 3))
                0: host_write(b);
                1: host_read();
                2: bus_read(1'b0);
                default: bus_write(b, 1'($urandom_range(0, 1)));
            endcase
            check_state("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
